dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port data memory (16-bit word address, 32-bit data, write on posedge, combinational read gated by mem_read).
- Shares the memory between port 0 (CPU load/store stage) and port 1 (DMA/debug loader) using a req/ack handshake.
- Arbitration is round-robin. Read data is registered and returned with ack.
- Owns every memory control signal; nothing else drives the memory.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/ack arbiter and sequencer for the single-port data memory.
// Each access is IDLE (grant) -> SERVE (memory cycle) -> RESP (ack + read data).
// Build option DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie (port 1 may starve);
// without it, ties are resolved round-robin against the last granted port.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              sel;
    logic              win_c;
    logic              win_we_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [DATA_W-1:0] win_wdata_c;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    // Winner selection among pending requests and mux of the winner's attributes
    always_comb begin
        win_c = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win_c = ~req0;
`else
        if (req0 && req1) begin
            win_c = ~last_grant;
        end else begin
            win_c = ~req0;
        end
`endif
        win_we_c    = win_c ? we1    : we0;
        win_addr_c  = win_c ? addr1  : addr0;
        win_wdata_c = win_c ? wdata1 : wdata0;
    end

    // Next-state logic: every access takes exactly one SERVE and one RESP cycle
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req0 || req1) next_state = ST_SERVE;
            ST_SERVE: next_state = ST_RESP;
            ST_RESP:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant latch, memory controls, read-data capture and ack pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel            <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant     <= 1'b1;
`endif
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            busy           <= (next_state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        // Memory controls double as the latched transaction for SERVE
                        sel            <= win_c;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_grant     <= win_c;
`endif
                        mem_address    <= win_addr_c;
                        mem_write_data <= win_wdata_c;
                        mem_write      <= win_we_c;
                        mem_read       <= ~win_we_c;
                    end
                end
                ST_SERVE: begin
                    // A write returns zero on the requester's rdata
                    if (sel) begin
                        rdata1 <= mem_write ? '0 : mem_read_data;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= mem_write ? '0 : mem_read_data;
                        ack0   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized two-port traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_write, mem_read, busy;
    logic [DW-1:0] rdata0, rdata1, mem_write_data, mem_read_data;
    logic [AW-1:0] mem_address;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ack1   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    // Data memory: write on posedge, combinational read gated by mem_read
    logic [DW-1:0] mem [0:65535] = '{default: '0};
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
    assign mem_read_data = mem_read ? mem[mem_address] : '0;

    // Reference model: a granted transaction accesses memory one cycle later and is acked the cycle after
    logic [DW-1:0] shadow [0:65535] = '{default: '0};
    int            m_cnt;      // 0 free, 1 access cycle, 2 ack cycle
    logic          m_sel, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd0, m_rd1;
    logic          m_win;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign m_win = req0 ? 1'b0 : req1;
`else
    logic m_last;
    assign m_win = (req0 && req1) ? ~m_last : req1;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_sel <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_rd0 <= '0; m_rd1 <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            m_last <= 1'b1;
`endif
        end else if (m_cnt == 2) begin
            m_cnt <= 0;
        end else if (m_cnt == 1) begin
            if (m_we) shadow[m_addr] <= m_wdata;
            if (m_sel) m_rd1 <= m_we ? '0 : shadow[m_addr];
            else       m_rd0 <= m_we ? '0 : shadow[m_addr];
            m_cnt <= 2;
        end else if (req0 || req1) begin
            m_sel   <= m_win;
            m_we    <= m_win ? we1 : we0;
            m_addr  <= m_win ? addr1 : addr0;
            m_wdata <= m_win ? wdata1 : wdata0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            m_last  <= m_win;
`endif
            m_cnt   <= 1;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare();
        chk("ack0", 32'(ack0), 32'(m_cnt == 2 && !m_sel));
        chk("ack1", 32'(ack1), 32'(m_cnt == 2 && m_sel));
        chk("ack_excl", 32'(ack0 & ack1), 32'd0);
        chk("rdata0", rdata0, m_rd0);
        chk("rdata1", rdata1, m_rd1);
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("mem_write", 32'(mem_write), 32'(m_cnt == 1 && m_we));
        chk("mem_read", 32'(mem_read), 32'(m_cnt == 1 && !m_we));
        chk("mem_address", 32'(mem_address), (m_cnt == 1) ? 32'(m_addr) : 32'd0);
        chk("mem_write_data", mem_write_data, (m_cnt == 1) ? m_wdata : 32'd0);
        if (ack1) n_ack1++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input bit p, input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && busy; i++) tick();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One complete transaction; cyc counts the cycle (1-based) in which ack is seen
    task automatic txn(input bit p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd, output int cyc);
        bit ok = 1'b0;
        wait_idle();
        set_port(p, 1'b1, w, a, d);
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
            if (p ? ack1 : ack0) begin ok = 1'b1; break; end
        end
        rd = p ? rdata1 : rdata0;
        set_port(p, 1'b0, 1'b0, '0, '0);
        chk("txn_timeout", 32'(ok), 32'd1);
        tick();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
    endfunction

    // Random requester obeying the req/ack rules, reshuffling attributes while waiting
    task automatic rand_port(input bit p, input int n);
        for (int t = 0; t < n; t++) begin
            bit ok = 1'b0;
            int gap = p ? $urandom_range(0, 3) : $urandom_range(2, 4);
            repeat (gap) tick();
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            for (int c = 0; c < 30; c++) begin
                tick();
                if (p ? ack1 : ack0) begin ok = 1'b1; break; end
                if ($urandom_range(0, 2) == 0)
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            set_port(p, 1'b0, 1'b0, '0, '0);
            chk("rand_timeout", 32'(ok), 32'd1);
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            cyc;
        int            k;
        int            ack1_before;
        bit            got1;
        int            order[$];

        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        // Reset state
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        rst_n = 1'b1;
        tick();

        // Port 0 write then read back, ack in third cycle
        txn(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, rd, cyc);
        chk("wr_latency", 32'(cyc), 32'd3);
        chk("wr_rdata0", rd, 32'd0);
        txn(1'b0, 1'b0, 16'h0010, '0, rd, cyc);
        chk("rd_latency", 32'(cyc), 32'd3);
        chk("rd_rdata0", rd, 32'hDEADBEEF);

        // Top address passes through unchanged
        ack1_before = n_ack1;
        txn(1'b1, 1'b1, 16'hFFFF, 32'h12345678, rd, cyc);
        txn(1'b0, 1'b0, 16'hFFFF, '0, rd, cyc);
        chk("ffff_rdata0", rd, 32'h12345678);
        chk("ffff_ack1_count", 32'(n_ack1 - ack1_before), 32'd1);

        // Reset during SERVE of a write must abort it
        txn(1'b0, 1'b1, 16'h0020, 32'h11111111, rd, cyc);
        wait_idle();
        set_port(1'b0, 1'b1, 1'b1, 16'h0020, 32'hA5A5A5A5);
        tick();
        chk("abort_serve_write", 32'(mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack0", 32'(ack0), 32'd0);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_mem_kept", mem[16'h0020], 32'h11111111);
        txn(1'b0, 1'b0, 16'h0020, '0, rd, cyc);
        chk("abort_readback", rd, 32'h11111111);

        // Port 0 read in flight while port 1 toggles its attributes
        txn(1'b0, 1'b1, 16'h0030, 32'h0BADF00D, rd, cyc);
        txn(1'b1, 1'b1, 16'h0040, 32'h40404040, rd, cyc);
        txn(1'b1, 1'b1, 16'h0041, 32'h41414141, rd, cyc);
        wait_idle();
        set_port(1'b0, 1'b1, 1'b0, 16'h0030, '0);
        tick();
        k = 0;
        got1 = 1'b0;
        set_port(1'b1, 1'b1, 1'(k), 16'h0040 | 16'(k & 1), 32'hCAFE0000 | 32'(k));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack0) begin
                chk("toggle_rdata0", rdata0, 32'h0BADF00D);
                req0 = 1'b0;
            end
            if (ack1) begin got1 = 1'b1; break; end
            k++;
            set_port(1'b1, 1'b1, 1'(k & 1), 16'h0040 | 16'(k & 1), 32'hCAFE0000 | 32'(k));
        end
        chk("toggle_ack1", 32'(got1), 32'd1);
        chk("toggle_rdata1", rdata1, 32'h40404040);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        tick();

        // Continuous contention from reset
        do_reset();
        set_port(1'b0, 1'b1, 1'b0, 16'h0001, '0);
        set_port(1'b1, 1'b1, 1'b0, 16'h0002, '0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        chk("contend_count", 32'(order.size() >= 10), 32'd1);
        for (int i = 0; i < 10 && i < order.size(); i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            chk($sformatf("contend_grant%0d", i), 32'(order[i]), 32'd0);
`else
            chk($sformatf("contend_grant%0d", i), 32'(order[i]), 32'(i % 2));
`endif
        end
        tick();
        wait_idle();

        // Randomized two-port traffic
        fork
            rand_port(1'b0, 60);
            rand_port(1'b1, 60);
        join
        tick();
        wait_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
